// File: rtl/camera_pkg.sv
// Camera-side types: scan FSM states, per-ray tag layout and integer-to-fixed helper.
package camera_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TAG_XY_W  = 16;
    localparam int TAG_IDX_W = 8;

    typedef struct packed {
        logic [TAG_XY_W-1:0]  pix_x;
        logic [TAG_XY_W-1:0]  pix_y;
        logic [TAG_IDX_W-1:0] sample_idx;
        logic                 pixel_last;
        logic                 frame_last;
    } ray_tag_t;

    function automatic vector::fixed_t to_fixed(input int v);
        return vector::fixed_t'(v) <<< vector::FRAC_W;
    endfunction
endpackage

// File: rtl/vector_pkg.sv
// Fixed-point scalar and 3-component vector types shared by the ray pipeline.
package vector;
    localparam int FRAC_W = 16;

    typedef logic signed [31:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vector_t;
endpackage

// File: rtl/scan_counter.sv
// Chained wrap counters walking sx -> sy -> pixel column -> pixel row.
module scan_counter #(
    parameter int H_WIDTH  = 1024,
    parameter int V_HEIGHT = 768,
    parameter int SS_LOG2  = 0,
    localparam int SW = (SS_LOG2 > 0) ? SS_LOG2 : 1,
    localparam int XW = $clog2(H_WIDTH),
    localparam int YW = $clog2(V_HEIGHT)
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [SW-1:0] sx,
    output logic [SW-1:0] sy,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic          pixLast,
    output logic          frameLast
);
    localparam logic [SW-1:0] S_MAX = SW'((1 << SS_LOG2) - 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_HEIGHT - 1);

    logic sxLast, syLast, pxLast, pyLast;

    assign sxLast    = (sx == S_MAX);
    assign syLast    = (sy == S_MAX);
    assign pxLast    = (px == X_MAX);
    assign pyLast    = (py == Y_MAX);
    assign pixLast   = sxLast & syLast;
    assign frameLast = pixLast & pxLast & pyLast;

    // Every counter wraps to zero on the final sample, so a continuous frame needs no clear.
    always_ff @(posedge pixel_clk) begin
        if (rst || clr) begin
            sx <= '0;
            sy <= '0;
            px <= '0;
            py <= '0;
        end else if (en) begin
            sx <= sxLast ? '0 : sx + SW'(1);
            if (sxLast)
                sy <= syLast ? '0 : sy + SW'(1);
            if (pixLast)
                px <= pxLast ? '0 : px + XW'(1);
            if (pixLast && pxLast)
                py <= pyLast ? '0 : py + YW'(1);
        end
    end
endmodule

// File: rtl/ray_generator.sv
// Streaming primary-ray source: scans a frame with optional supersampling and
// emits one unnormalized view-space direction per sample over valid/ready.
//
// state | meaning
// IDLE  | no frame in progress, waiting for start
// RUN   | presenting samples, advancing on each handshake
module ray_generator
    import camera_pkg::*;
#(
    parameter int H_WIDTH  = 1024,
    parameter int V_HEIGHT = 768,
    parameter int SS_LOG2  = 0,
    parameter int Z_DEPTH  = 1,
    localparam int SW = (SS_LOG2 > 0) ? SS_LOG2 : 1,
    localparam int XW = $clog2(H_WIDTH),
    localparam int YW = $clog2(V_HEIGHT),
    localparam int IW = (SS_LOG2 > 0) ? 2 * SS_LOG2 : 1
) (
    input  logic            pixel_clk,
    input  logic            rst,
    input  logic            start,
    input  logic            continuous,
    input  logic [1:0]      fov_shift,
    output logic            busy,
    output logic            frame_done,
    output logic            out_valid,
    input  logic            out_ready,
    output vector::vector_t ray,
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic [IW-1:0]   sample_idx,
    output logic            pixel_last,
    output logic            frame_last
);
    localparam int S = 1 << SS_LOG2;

    state_t        state, stateNxt;
    logic          cntClr, cntEn, fovLoad, lastHs;
    logic [1:0]    fovLat;
    logic [SW-1:0] sx, sy;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          pixLast, frameLast;
    logic [IW-1:0] sIdx;
    int            u, w, dx, dy;

    scan_counter #(
        .H_WIDTH (H_WIDTH),
        .V_HEIGHT(V_HEIGHT),
        .SS_LOG2 (SS_LOG2)
    ) u_scan (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .clr      (cntClr),
        .en       (cntEn),
        .sx       (sx),
        .sy       (sy),
        .px       (px),
        .py       (py),
        .pixLast  (pixLast),
        .frameLast(frameLast)
    );

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state      <= IDLE;
            fovLat     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNxt;
            frame_done <= lastHs;
            if (fovLoad)
                fovLat <= fov_shift;
        end
    end

    // In RUN out_valid is always high, so out_ready alone marks a handshake.
    always_comb begin
        stateNxt = state;
        cntClr   = 1'b0;
        cntEn    = 1'b0;
        fovLoad  = 1'b0;
        lastHs   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNxt = RUN;
                    cntClr   = 1'b1;
                    fovLoad  = 1'b1;
                end
            end
            RUN: begin
                if (out_ready) begin
                    cntEn = 1'b1;
                    if (frameLast) begin
                        lastHs = 1'b1;
                        if (continuous)
                            fovLoad = 1'b1;
                        else
                            stateNxt = IDLE;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);

    generate
        if (SS_LOG2 > 0) begin : g_ss
            assign sIdx = {sy, sx};
        end else begin : g_noss
            assign sIdx = '0;
        end
    endgenerate

    // Odd offsets from the frame centre; y is flipped so the top row is positive.
    assign u  = (int'(px) << SS_LOG2) + int'(sx);
    assign w  = (int'(py) << SS_LOG2) + int'(sy);
    assign dx = 2 * u + 1 - H_WIDTH * S;
    assign dy = V_HEIGHT * S - 1 - 2 * w;

    always_comb begin
        ray        = '0;
        pix_x      = '0;
        pix_y      = '0;
        sample_idx = '0;
        pixel_last = 1'b0;
        frame_last = 1'b0;
        if (out_valid) begin
            ray.x      = to_fixed(dx <<< fovLat);
            ray.y      = to_fixed(dy <<< fovLat);
            ray.z      = to_fixed(Z_DEPTH);
            pix_x      = px;
            pix_y      = py;
            sample_idx = sIdx;
            pixel_last = pixLast;
            frame_last = frameLast;
        end
    end
endmodule

// File: tb/tb_ray_generator.sv
// Directed bench for ray_generator: a 4x2 frame with 2x2 supersampling and a 4x2 frame without.
module tb_ray_generator;
    import camera_pkg::*;

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;

    logic startA = 0, contA = 0, readyA = 1;
    logic [1:0] fovA = 2'd1;
    logic busyA, doneA, validA, plA, flA;
    vector::vector_t rayA;
    logic [1:0] pxA;
    logic [0:0] pyA;
    logic [1:0] idxA;

    logic startB = 0, contB = 0, readyB = 1;
    logic [1:0] fovB = 2'd0;
    logic busyB, doneB, validB, plB, flB;
    vector::vector_t rayB;
    logic [1:0] pxB;
    logic [0:0] pyB;
    logic [0:0] idxB;

    int nCmp = 0, nBad = 0;
    int capX[64], capY[64];

    always #5 pixel_clk = ~pixel_clk;

    ray_generator #(.H_WIDTH(4), .V_HEIGHT(2), .SS_LOG2(1), .Z_DEPTH(1)) dutA (
        .pixel_clk(pixel_clk), .rst(rst), .start(startA), .continuous(contA),
        .fov_shift(fovA), .busy(busyA), .frame_done(doneA), .out_valid(validA),
        .out_ready(readyA), .ray(rayA), .pix_x(pxA), .pix_y(pyA),
        .sample_idx(idxA), .pixel_last(plA), .frame_last(flA));

    ray_generator #(.H_WIDTH(4), .V_HEIGHT(2), .SS_LOG2(0), .Z_DEPTH(1)) dutB (
        .pixel_clk(pixel_clk), .rst(rst), .start(startB), .continuous(contB),
        .fov_shift(fovB), .busy(busyB), .frame_done(doneB), .out_valid(validB),
        .out_ready(readyB), .ray(rayB), .pix_x(pxB), .pix_y(pyB),
        .sample_idx(idxB), .pixel_last(plB), .frame_last(flB));

    typedef struct {
        int       x;
        int       y;
        ray_tag_t tag;
    } vec_t;

    typedef struct {
        int n;
        int x;
        int y;
    } key_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected sample k of the 4x2, 2x2-supersampled frame.
    function automatic void modelA(input int k, input int fov, output int x, output int y,
                                   output int px, output int py, output int idx,
                                   output bit pl, output bit fl);
        int sx, sy, u, w;
        sx  = k % 2;
        sy  = (k / 2) % 2;
        px  = (k / 4) % 4;
        py  = k / 16;
        u   = px * 2 + sx;
        w   = py * 2 + sy;
        x   = (2 * u + 1 - 8) * (1 << fov);
        y   = (3 - 2 * w) * (1 << fov);
        idx = sy * 2 + sx;
        pl  = (sx == 1) && (sy == 1);
        fl  = (k == 31);
    endfunction

    task automatic pulseStartA();
        @(negedge pixel_clk);
        startA = 1'b1;
        @(negedge pixel_clk);
        startA = 1'b0;
    endtask

    task automatic scanA(input int total, input int fov0, input int fov1, input bit rnd,
                         input int pokeAt, input int fovAt, input int contOffAt, output int hs);
        int n = 0, cyc = 0;
        int ex, ey, epx, epy, eidx;
        bit epl, efl, wasStall = 0, expDone = 0;
        logic [102:0] snap, prevSnap;
        prevSnap = '0;
        hs = 0;
        while (n < total) begin
            if (cyc >= 4000) begin
                chk("scan_timeout", n, total);
                break;
            end
            modelA(n % 32, (n < 32) ? fov0 : fov1, ex, ey, epx, epy, eidx, epl, efl);
            chk("out_valid", validA, 1);
            chk("busy", busyA, 1);
            chk("frame_done", doneA, expDone);
            chk("ray_x", $signed(rayA.x), ex * 65536);
            chk("ray_y", $signed(rayA.y), ey * 65536);
            chk("ray_z", $signed(rayA.z), 65536);
            chk("pix_x", pxA, epx);
            chk("pix_y", pyA, epy);
            chk("sample_idx", idxA, eidx);
            chk("pixel_last", plA, epl);
            chk("frame_last", flA, efl);
            snap = {rayA, pxA, pyA, idxA, plA, flA};
            if (wasStall) begin
                nCmp++;
                if (snap !== prevSnap) begin
                    nBad++;
                    $display("FAIL stall_hold: outputs %h changed, held %h", snap, prevSnap);
                end
            end
            capX[n] = int'($signed(rayA.x)) >>> 16;
            capY[n] = int'($signed(rayA.y)) >>> 16;
            readyA = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            startA = (n == pokeAt);
            if (n == fovAt) fovA = 2'd0;
            if (n == contOffAt) contA = 1'b0;
            expDone  = readyA && efl;
            wasStall = !readyA;
            prevSnap = snap;
            if (readyA) begin
                n++;
                hs++;
            end
            cyc++;
            @(negedge pixel_clk);
        end
        startA = 1'b0;
        readyA = 1'b1;
        chk("frame_done_end", doneA, expDone);
    endtask

    task automatic chkIdleA(input string nm);
        chk({nm, "_valid"}, validA, 0);
        chk({nm, "_busy"}, busyA, 0);
    endtask

    initial begin
        vec_t vecB[8];
        key_t keyA[6];
        int hs;

        // 4x2 frame, no supersampling, fov 0: x steps -3..3, y is 1 then -1.
        vecB[0] = '{-3,  1, '{16'd0, 16'd0, 8'd0, 1'b1, 1'b0}};
        vecB[1] = '{-1,  1, '{16'd1, 16'd0, 8'd0, 1'b1, 1'b0}};
        vecB[2] = '{ 1,  1, '{16'd2, 16'd0, 8'd0, 1'b1, 1'b0}};
        vecB[3] = '{ 3,  1, '{16'd3, 16'd0, 8'd0, 1'b1, 1'b0}};
        vecB[4] = '{-3, -1, '{16'd0, 16'd1, 8'd0, 1'b1, 1'b0}};
        vecB[5] = '{-1, -1, '{16'd1, 16'd1, 8'd0, 1'b1, 1'b0}};
        vecB[6] = '{ 1, -1, '{16'd2, 16'd1, 8'd0, 1'b1, 1'b0}};
        vecB[7] = '{ 3, -1, '{16'd3, 16'd1, 8'd0, 1'b1, 1'b1}};

        // Hand-picked samples of the 2x2-supersampled frame at fov 1.
        keyA[0] = '{0,  -14,  6};
        keyA[1] = '{1,  -10,  6};
        keyA[2] = '{2,  -14,  2};
        keyA[3] = '{4,   -6,  6};
        keyA[4] = '{19, -10, -6};
        keyA[5] = '{31,  14, -6};

        repeat (3) @(negedge pixel_clk);
        chk("rst_valid", validA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_ray_x", $signed(rayA.x), 0);
        chk("rst_ray_y", $signed(rayA.y), 0);
        chk("rst_ray_z", $signed(rayA.z), 0);
        chk("rst_pix_x", pxA, 0);
        chk("rst_pixel_last", plA, 0);
        chk("rst_b_pixel_last", plB, 0);
        rst = 1'b0;

        @(negedge pixel_clk);
        startB = 1'b1;
        @(negedge pixel_clk);
        startB = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b_valid", validB, 1);
            chk("b_ray_x", $signed(rayB.x), vecB[i].x * 65536);
            chk("b_ray_y", $signed(rayB.y), vecB[i].y * 65536);
            chk("b_ray_z", $signed(rayB.z), 65536);
            chk("b_pix_x", pxB, vecB[i].tag.pix_x);
            chk("b_pix_y", pyB, vecB[i].tag.pix_y);
            chk("b_sample_idx", idxB, vecB[i].tag.sample_idx);
            chk("b_pixel_last", plB, vecB[i].tag.pixel_last);
            chk("b_frame_last", flB, vecB[i].tag.frame_last);
            @(negedge pixel_clk);
        end
        chk("b_frame_done", doneB, 1);
        chk("b_busy_end", busyB, 0);
        chk("b_valid_end", validB, 0);

        fovA = 2'd1;
        pulseStartA();
        scanA(32, 1, 1, 0, -1, -1, -1, hs);
        chkIdleA("single_end");
        for (int i = 0; i < 6; i++) begin
            chk("keyA_x", capX[keyA[i].n], keyA[i].x);
            chk("keyA_y", capY[keyA[i].n], keyA[i].y);
        end
        @(negedge pixel_clk);
        chk("frame_done_pulse_width", doneA, 0);

        pulseStartA();
        scanA(32, 1, 1, 1, -1, -1, -1, hs);
        chk("stall_handshakes", hs, 32);
        chkIdleA("stall_end");

        pulseStartA();
        scanA(32, 1, 1, 0, 5, -1, -1, hs);
        chkIdleA("start_busy_end");

        fovA = 2'd1;
        contA = 1'b1;
        pulseStartA();
        scanA(64, 1, 0, 0, -1, 5, 40, hs);
        chk("cont_second_x", capX[32], -7);
        chk("cont_second_y", capY[32], 3);
        chkIdleA("cont_end");

        fovA = 2'd1;
        pulseStartA();
        scanA(10, 1, 1, 0, -1, -1, -1, hs);
        rst = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
        chkIdleA("mid_rst");
        chk("mid_rst_done", doneA, 0);
        repeat (3) begin
            @(negedge pixel_clk);
            chk("post_rst_done", doneA, 0);
            chk("post_rst_valid", validA, 0);
        end
        pulseStartA();
        scanA(32, 1, 1, 0, -1, -1, -1, hs);
        chkIdleA("restart_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
